// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable program memory plus PC, one word presented to the CU at a time.
// Optional feature macro: IFU_JUMP_EN (adds jump_en / jump_addr redirect on retire).
module instr_fetch #(
   parameter int INSTR_WIDTH = 20,
   parameter int PC_BITS     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   load_en,
   input  logic [PC_BITS-1:0]     load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   instr_ready,
`ifdef IFU_JUMP_EN
   input  logic                   jump_en,
   input  logic [PC_BITS-1:0]     jump_addr,
`endif
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic [PC_BITS-1:0]     pc,
   output logic                   halted
);

   localparam int                 DEPTH   = 2**PC_BITS;
   localparam int                 CLS_HI  = INSTR_WIDTH - 1;
   localparam int                 CLS_LO  = INSTR_WIDTH - 2;
   localparam logic [PC_BITS-1:0] LAST_PC = {PC_BITS{1'b1}};
   localparam logic [PC_BITS-1:0] ZERO_PC = {PC_BITS{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_FETCH   = 2'b01,
      ST_PRESENT = 2'b10,
      ST_HALT    = 2'b11
   } state_t;

   state_t                 state_r, state_nxt_s;
   logic [INSTR_WIDTH-1:0] mem_r [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_r;
   logic                   valid_r;
   logic [PC_BITS-1:0]     pc_r, pc_nxt_s;
   logic                   halted_r, halted_nxt_s;
   logic                   fetch_s, clear_s, mem_we_s;
   logic                   jump_take_s;
   logic [PC_BITS-1:0]     jump_tgt_s;

   // A class field of zero marks the halt word.
   function automatic logic is_halt_word(input logic [INSTR_WIDTH-1:0] w);
      return (w[CLS_HI:CLS_LO] == 2'b00);
   endfunction

`ifdef IFU_JUMP_EN
   assign jump_take_s = jump_en;
   assign jump_tgt_s  = jump_addr;
`else
   assign jump_take_s = 1'b0;
   assign jump_tgt_s  = ZERO_PC;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; valid_r low in PRESENT means the fetched word was a halt word
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_HALT: begin
            if (start) state_nxt_s = ST_FETCH;
            else       state_nxt_s = state_r;
         end
         ST_FETCH: state_nxt_s = ST_PRESENT;
         ST_PRESENT: begin
            if (!valid_r)                state_nxt_s = ST_HALT;
            else if (!instr_ready)       state_nxt_s = ST_PRESENT;
            else if (jump_take_s)        state_nxt_s = ST_FETCH;
            else if (pc_r == LAST_PC)    state_nxt_s = ST_HALT;
            else                         state_nxt_s = ST_FETCH;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output / datapath control decoded from the current state
   always_comb begin
      pc_nxt_s     = pc_r;
      halted_nxt_s = halted_r;
      fetch_s      = 1'b0;
      clear_s      = 1'b0;
      mem_we_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_HALT: begin
            mem_we_s = load_en;
            if (start) begin
               pc_nxt_s     = ZERO_PC;
               halted_nxt_s = 1'b0;
            end else begin
               pc_nxt_s     = pc_r;
               halted_nxt_s = halted_r;
            end
         end
         ST_FETCH: fetch_s = 1'b1;
         ST_PRESENT: begin
            if (!valid_r) begin
               clear_s      = 1'b1;
               halted_nxt_s = 1'b1;
            end else if (instr_ready) begin
               clear_s = 1'b1;
               if (jump_take_s)          pc_nxt_s     = jump_tgt_s;
               else if (pc_r == LAST_PC) halted_nxt_s = 1'b1;
               else                      pc_nxt_s     = pc_r + PC_BITS'(1);
            end else begin
               clear_s = 1'b0;
            end
         end
         default: begin
            clear_s      = 1'b1;
            pc_nxt_s     = ZERO_PC;
            halted_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered outputs; instr_r doubles as the synchronous read register of the memory
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r     <= ZERO_PC;
         halted_r <= 1'b0;
         instr_r  <= {INSTR_WIDTH{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         pc_r     <= pc_nxt_s;
         halted_r <= halted_nxt_s;
         if (fetch_s) begin
            instr_r <= mem_r[pc_r];
            valid_r <= !is_halt_word(mem_r[pc_r]);
         end else if (clear_s) begin
            instr_r <= {INSTR_WIDTH{1'b0}};
            valid_r <= 1'b0;
         end
      end
   end

   // Program memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) mem_r[load_addr] <= load_data;
   end

   assign instr       = instr_r;
   assign instr_valid = valid_r;
   assign pc          = pc_r;
   assign halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand sequences and
// randomized programs checked against a program-level reference model.
module tb_instr_fetch;
   localparam int W     = 20;
   localparam int PB    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, load_en, instr_ready;
   logic [PB-1:0] load_addr;
   logic [W-1:0]  load_data;
   logic [W-1:0]  instr;
   logic          instr_valid;
   logic [PB-1:0] pc;
   logic          halted;
`ifdef IFU_JUMP_EN
   logic          jump_en;
   logic [PB-1:0] jump_addr;
`endif

   int errors = 0;
   int checks = 0;
   logic [W-1:0] model_mem [DEPTH];

   instr_fetch #(.INSTR_WIDTH(W), .PC_BITS(PB)) dut (
      .clk(clk), .rst(rst), .start(start), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .instr_ready(instr_ready),
`ifdef IFU_JUMP_EN
      .jump_en(jump_en), .jump_addr(jump_addr),
`endif
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          st;
      logic          ld;
      logic [PB-1:0] la;
      logic [W-1:0]  ldd;
      logic          rdy;
      logic [W-1:0]  e_instr;
      logic          e_valid;
      logic [PB-1:0] e_pc;
      logic          e_halt;
   } vec_t;

   vec_t vt [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      start = 1'b0; load_en = 1'b0; instr_ready = 1'b0;
      load_addr = '0; load_data = '0;
`ifdef IFU_JUMP_EN
      jump_en = 1'b0; jump_addr = '0;
`endif
   endtask

   task automatic check_all(input string tag, input logic [W-1:0] ei, input logic ev,
                            input logic [PB-1:0] ep, input logic eh);
      check({tag, " instr"},  32'(instr),       32'(ei));
      check({tag, " valid"},  32'(instr_valid), 32'(ev));
      check({tag, " pc"},     32'(pc),          32'(ep));
      check({tag, " halted"}, 32'(halted),      32'(eh));
   endtask

   task automatic write_mem(input logic [PB-1:0] a, input logic [W-1:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
      model_mem[a] = d;
   endtask

   // Spurious writes that a fetching unit must ignore; the model stays untouched.
   task automatic noise_write();
      load_en   = 1'($urandom_range(0, 1));
      load_addr = PB'($urandom);
      load_data = W'($urandom);
   endtask

   // Entered during the FETCH cycle of address 0; follows the program from model_mem.
   task automatic run_program(input int run);
      int p = 0;
      for (int n = 0; n <= DEPTH; n++) begin
         check($sformatf("r%0d gap valid", run), 32'(instr_valid), 32'd0);
         check($sformatf("r%0d gap pc", run), 32'(pc), 32'(p));
         instr_ready = 1'($urandom_range(0, 1));
         noise_write();
         tick();
         quiet();
         if (model_mem[p][19:18] == 2'b00) begin
            check($sformatf("r%0d haltword valid", run), 32'(instr_valid), 32'd0);
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            quiet();
            check_all($sformatf("r%0d halt@%0d", run, p), '0, 1'b0, PB'(p), 1'b1);
            return;
         end
         check_all($sformatf("r%0d present@%0d", run, p), model_mem[p], 1'b1, PB'(p), 1'b0);
         for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
            noise_write();
            tick();
            quiet();
            check($sformatf("r%0d hold@%0d", run, p), 32'(instr), 32'(model_mem[p]));
         end
         instr_ready = 1'b1;
         tick();
         quiet();
         check($sformatf("r%0d retire instr", run), 32'(instr), 32'd0);
         if (p == DEPTH - 1) begin
            check_all($sformatf("r%0d endmem", run), '0, 1'b0, PB'(p), 1'b1);
            return;
         end
         p++;
      end
      check("run bound", 32'd1, 32'd0);
   endtask

   initial begin
      quiet();
      rst = 1'b1;
      #12;
      check_all("reset", '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: load three words, run to the halt word, restart.
      vt[0]  = '{1'b0, 1'b1, 5'd0, 20'h41000, 1'b0, 20'h0,     1'b0, 5'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 5'd1, 20'h92010, 1'b0, 20'h0,     1'b0, 5'd0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 5'd2, 20'h00000, 1'b0, 20'h0,     1'b0, 5'd0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h0,     1'b0, 5'd0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h41000, 1'b1, 5'd0, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h41000, 1'b1, 5'd0, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b1, 20'h0,     1'b0, 5'd1, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h92010, 1'b1, 5'd1, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b1, 20'h0,     1'b0, 5'd2, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h0,     1'b0, 5'd2, 1'b0};
      vt[10] = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h0,     1'b0, 5'd2, 1'b1};
      vt[11] = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b1, 20'h0,     1'b0, 5'd2, 1'b1};
      vt[12] = '{1'b1, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h0,     1'b0, 5'd0, 1'b0};
      vt[13] = '{1'b0, 1'b0, 5'd0, 20'h00000, 1'b0, 20'h41000, 1'b1, 5'd0, 1'b0};
      @(posedge clk);
      #1;
      for (int i = 0; i < 14; i++) begin
         start = vt[i].st; load_en = vt[i].ld; load_addr = vt[i].la;
         load_data = vt[i].ldd; instr_ready = vt[i].rdy;
         tick();
         quiet();
         check_all($sformatf("vec%0d", i), vt[i].e_instr, vt[i].e_valid, vt[i].e_pc, vt[i].e_halt);
      end

      // Stall: instruction and pc held while the CU is busy.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_all($sformatf("stall%0d", i), 20'h41000, 1'b1, 5'd0, 1'b0);
      end

      // Asynchronous reset in the middle of PRESENT.
      #2 rst = 1'b1;
      #1 check_all("midreset", '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Writes during PRESENT are dropped; readback via a second run.
      start = 1'b1; tick(); quiet(); tick();
      check_all("wr_ign pres", 20'h41000, 1'b1, 5'd0, 1'b0);
      load_en = 1'b1; load_addr = 5'd0; load_data = 20'h00000;
      tick(); quiet();
      instr_ready = 1'b1; tick(); quiet(); tick();
      check_all("wr_ign pc1", 20'h92010, 1'b1, 5'd1, 1'b0);
      instr_ready = 1'b1; tick(); quiet(); tick(); tick();
      check_all("wr_ign halt", '0, 1'b0, 5'd2, 1'b1);
      start = 1'b1; tick(); quiet(); tick();
      check_all("wr_ign readback", 20'h41000, 1'b1, 5'd0, 1'b0);

      rst = 1'b1; tick(); rst = 1'b0; tick();

      // Random programs; run 0 has no halt word so it walks off the end of memory.
      for (int run = 0; run < 6; run++) begin
         logic [W-1:0] d;
         for (int a = 1; a < DEPTH; a++) begin
            d = W'($urandom);
            if (run == 0 || $urandom_range(0, 7) != 0) d[18] = 1'b1;
            else                                     d[19:18] = 2'b00;
            write_mem(PB'(a), d);
         end
         d = W'($urandom);
         d[19] = 1'b1;
         start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = d;
         tick();
         quiet();
         model_mem[0] = d;
         run_program(run);
      end

`ifdef IFU_JUMP_EN
      for (int a = 0; a < 5; a++) write_mem(PB'(a), 20'h40000 | W'(a + 1));
      start = 1'b1; tick(); quiet();
      for (int a = 0; a < 3; a++) begin
         tick();
         instr_ready = 1'b1; tick(); quiet();
      end
      tick();
      check_all("jump pre", 20'h40004, 1'b1, 5'd3, 1'b0);
      instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 5'd0;
      tick(); quiet(); tick();
      check_all("jump target", 20'h40001, 1'b1, 5'd0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
